mandel_pixel_scheduler: RTL



---
 rtl/mandel_pkg.sv | 31 +++
 rtl/mandel_pixel_scheduler_color_map.sv | 14 +
 rtl/mandel_pixel_scheduler.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mandel_pkg.sv
// Shared widths, scheduler state encoding and the iteration-count to colour palette
// used by the Mandelbrot pixel scheduler.
package mandel_pkg;

  localparam int FRAC_BITS = 23;
  localparam int COORD_W   = 27;
  localparam int ITER_W    = 16;
  localparam int COLOR_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_WRITE
  } state_e;

  // Points that reach the limit are inside the set and drawn black; escapees
  // get count+1 so that an immediate escape is still distinguishable from black.
  function automatic logic [COLOR_W-1:0] colour_map(input logic [ITER_W-1:0] count,
                                                    input logic [ITER_W-1:0] max_iter);
    logic [ITER_W-1:0] bumped;
    bumped = count + ITER_W'(1);
    if (count >= max_iter)
      return '0;
    else if (count >= ITER_W'(254))
      return '1;
    else
      return bumped[COLOR_W-1:0];
  endfunction

endpackage

// File: rtl/mandel_pixel_scheduler_color_map.sv
// Combinational palette stage: turns a captured iteration count into a pixel colour.
module mandel_color_map
  import mandel_pkg::*;
(
  input  logic [ITER_W-1:0]  count,
  input  logic [ITER_W-1:0]  max_iter,
  output logic [COLOR_W-1:0] colour
);

  always_comb begin
    colour = colour_map(count, max_iter);
  end

endmodule

// File: rtl/mandel_pixel_scheduler.sv
// Raster walker that launches the iterator once per pixel and writes the resulting
// colour to a linear framebuffer address.
module mandel_pixel_scheduler
  import mandel_pkg::*;
#(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [COORD_W-1:0] cr_min,
  input  logic signed [COORD_W-1:0] ci_max,
  input  logic signed [COORD_W-1:0] step,
  input  logic [ITER_W-1:0]         max_iterations,
  output logic signed [COORD_W-1:0] iter_cr,
  output logic signed [COORD_W-1:0] iter_ci,
  output logic [ITER_W-1:0]         iter_max,
  output logic                      iter_reset,
  input  logic                      iter_done,
  input  logic [ITER_W-1:0]         iter_count,
  output logic [ADDR_W-1:0]         fb_addr,
  output logic [COLOR_W-1:0]        fb_data,
  output logic                      fb_we,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;

  state_e                    state_q, state_d;
  logic [X_W-1:0]            x_q, x_d;
  logic [Y_W-1:0]            y_q, y_d;
  logic signed [COORD_W-1:0] cur_cr_q, cur_cr_d;
  logic signed [COORD_W-1:0] cur_ci_q, cur_ci_d;
  logic signed [COORD_W-1:0] cr_min_q, cr_min_d;
  logic signed [COORD_W-1:0] step_q, step_d;
  logic [ITER_W-1:0]         max_q, max_d;
  logic [ITER_W-1:0]         count_q, count_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      frame_done_q, frame_done_d;
  logic [COLOR_W-1:0]        colour;
  logic                      last_x, last_y;

  assign last_x = (x_q == X_W'(H_RES - 1));
  assign last_y = (y_q == Y_W'(V_RES - 1));

  mandel_color_map u_color_map (
    .count    (count_q),
    .max_iter (max_q),
    .colour   (colour)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      cur_cr_q     <= '0;
      cur_ci_q     <= '0;
      cr_min_q     <= '0;
      step_q       <= '0;
      max_q        <= '0;
      count_q      <= '0;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cur_cr_q     <= cur_cr_d;
      cur_ci_q     <= cur_ci_d;
      cr_min_q     <= cr_min_d;
      step_q       <= step_d;
      max_q        <= max_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  // A start coinciding with the frame_done pulse is dropped so a held start
  // cannot silently chain frames back to back.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    cur_cr_d     = cur_cr_q;
    cur_ci_d     = cur_ci_q;
    cr_min_d     = cr_min_q;
    step_d       = step_q;
    max_d        = max_q;
    count_d      = count_q;
    addr_d       = addr_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !frame_done_q) begin
          cr_min_d = cr_min;
          step_d   = step;
          max_d    = max_iterations;
          x_d      = '0;
          y_d      = '0;
          cur_cr_d = cr_min;
          cur_ci_d = ci_max;
          addr_d   = '0;
          state_d  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (iter_done) begin
          count_d = iter_count;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d = addr_q + ADDR_W'(1);
        if (last_x) begin
          x_d      = '0;
          y_d      = y_q + Y_W'(1);
          cur_cr_d = cr_min_q;
          cur_ci_d = cur_ci_q - step_q;
        end else begin
          x_d      = x_q + X_W'(1);
          cur_cr_d = cur_cr_q + step_q;
        end
        if (last_x && last_y) begin
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_LAUNCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Coordinates only advance on leaving WRITE, so they stay steady for the whole pixel.
  always_comb begin
    iter_cr    = cur_cr_q;
    iter_ci    = cur_ci_q;
    iter_max   = max_q;
    iter_reset = (state_q != ST_WAIT);
    fb_we      = (state_q == ST_WRITE);
    fb_addr    = addr_q;
    fb_data    = (state_q == ST_WRITE) ? colour : '0;
    busy       = (state_q != ST_IDLE);
    frame_done = frame_done_q;
  end

endmodule
